// File: rtl/spn_cu_pkg.sv
// rtl/spn_cu_pkg.sv - SPN crypto-unit opcodes, status codes and arbiter state type.
package spn_cu_pkg;

   localparam logic [1:0] OP_NO_OP    = 2'b00;
   localparam logic [1:0] OP_ENCRYPT  = 2'b01;
   localparam logic [1:0] OP_DECRYPT  = 2'b10;
   localparam logic [1:0] OP_UNDEF    = 2'b11;

   localparam logic [1:0] STS_NOT_VALID    = 2'b00;
   localparam logic [1:0] STS_ENCRYPT_OK   = 2'b01;
   localparam logic [1:0] STS_DECRYPT_OK   = 2'b10;
   localparam logic [1:0] STS_INTERNAL_ERR = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      CAPTURE,
      RESP
   } spn_arb_state_t;

   // Status the core must report for a given opcode when it behaves correctly.
   function automatic logic [1:0] spn_expected_status(input logic [1:0] op);
      logic [1:0] sts;
      case (op)
         OP_ENCRYPT: sts = STS_ENCRYPT_OK;
         OP_DECRYPT: sts = STS_DECRYPT_OK;
         OP_UNDEF:   sts = STS_INTERNAL_ERR;
         default:    sts = STS_NOT_VALID;
      endcase
      return sts;
   endfunction

endpackage

// File: rtl/spn_rr_arbiter.sv
// rtl/spn_rr_arbiter.sv - Combinational round-robin pick starting after the last granted index.
module spn_rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [ID_W-1:0]    i_ptr,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [ID_W-1:0]    o_idx,
   output logic               o_any
);

   always_comb begin
      int            w_cand;
      logic [ID_W-1:0] w_cand_idx;
      w_cand     = 0;
      w_cand_idx = '0;
      o_grant    = '0;
      o_idx      = '0;
      o_any      = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         w_cand     = (int'(i_ptr) + k) % NUM_REQ;
         w_cand_idx = ID_W'(w_cand);
         if (!o_any && i_req[w_cand_idx]) begin
            o_any               = 1'b1;
            o_grant[w_cand_idx] = 1'b1;
            o_idx               = w_cand_idx;
         end
      end
   end

endmodule

// File: rtl/spn_cu_arbiter.sv
// rtl/spn_cu_arbiter.sv - Round-robin sharing of one SPN crypto core among NUM_REQ requesters.
// Optional per-requester grant counters are built when SPN_ARB_STATS_EN is defined.
module spn_cu_arbiter
   import spn_cu_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int KEY_W   = 32
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_REQ-1:0]              req_valid,
   output logic [NUM_REQ-1:0]              req_ready,
   input  logic [NUM_REQ-1:0][1:0]         req_opcode,
   input  logic [NUM_REQ-1:0][15:0]        req_data,
   input  logic [NUM_REQ-1:0][KEY_W-1:0]   req_key,
   output logic [NUM_REQ-1:0]              resp_valid,
   input  logic [NUM_REQ-1:0]              resp_ready,
   output logic [15:0]                     resp_data,
   output logic [1:0]                      resp_status,
   output logic [1:0]                      core_opcode,
   output logic [15:0]                     core_data_in,
   output logic [KEY_W-1:0]                core_key,
   input  logic [15:0]                     core_data_out,
   input  logic [1:0]                      core_valid,
   output logic                            busy,
   output logic                            err_sticky,
   output logic [NUM_REQ-1:0][15:0]        grant_count
);

   localparam int ID_W = $clog2(NUM_REQ);

   spn_arb_state_t    r_state;
   spn_arb_state_t    w_state_nxt;
   logic [ID_W-1:0]   r_ptr;
   logic [ID_W-1:0]   r_gnt;
   logic [1:0]        r_op;
   logic [15:0]       r_data;
   logic [KEY_W-1:0]  r_key;
   logic [15:0]       r_resp_data;
   logic [1:0]        r_resp_status;
   logic              r_err;
   logic [NUM_REQ-1:0] w_rr_grant;
   logic [ID_W-1:0]   w_rr_idx;
   logic              w_rr_any;
   logic              w_accept;

   spn_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr (
      .i_req   (req_valid),
      .i_ptr   (r_ptr),
      .o_grant (w_rr_grant),
      .o_idx   (w_rr_idx),
      .o_any   (w_rr_any)
   );

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   // Grants are suppressed while rst is high so no acceptance is visible during reset.
   always_comb begin
      w_state_nxt = r_state;
      req_ready   = '0;
      resp_valid  = '0;
      core_opcode = OP_NO_OP;
      case (r_state)
         IDLE: begin
            if (w_rr_any && !rst) begin
               req_ready   = w_rr_grant;
               w_state_nxt = (req_opcode[w_rr_idx] == OP_NO_OP) ? RESP : ISSUE;
            end
         end
         ISSUE: begin
            core_opcode = r_op;
            w_state_nxt = CAPTURE;
         end
         CAPTURE: w_state_nxt = RESP;
         RESP: begin
            resp_valid[r_gnt] = 1'b1;
            if (resp_ready[r_gnt]) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign w_accept = |req_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr         <= ID_W'(NUM_REQ - 1);
         r_gnt         <= '0;
         r_op          <= OP_NO_OP;
         r_data        <= '0;
         r_key         <= '0;
         r_resp_data   <= '0;
         r_resp_status <= STS_NOT_VALID;
         r_err         <= 1'b0;
      end else begin
         if (w_accept) begin
            r_gnt  <= w_rr_idx;
            r_ptr  <= w_rr_idx;
            r_op   <= req_opcode[w_rr_idx];
            r_data <= req_data[w_rr_idx];
            r_key  <= req_key[w_rr_idx];
            if (req_opcode[w_rr_idx] == OP_NO_OP) begin
               r_resp_data   <= '0;
               r_resp_status <= STS_NOT_VALID;
            end
         end
         if (r_state == CAPTURE) begin
            r_resp_data <= core_data_out;
            if (core_valid != spn_expected_status(r_op)) begin
               r_resp_status <= STS_INTERNAL_ERR;
               r_err         <= 1'b1;
            end else begin
               r_resp_status <= core_valid;
            end
         end
      end
   end

   assign core_data_in = r_data;
   assign core_key     = r_key;
   assign resp_data    = r_resp_data;
   assign resp_status  = r_resp_status;
   assign err_sticky   = r_err;
   assign busy         = (r_state != IDLE);

`ifdef SPN_ARB_STATS_EN
   logic [NUM_REQ-1:0][15:0] r_grant_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_grant_count <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i] && (r_grant_count[i] != 16'hFFFF))
               r_grant_count[i] <= r_grant_count[i] + 16'd1;
         end
      end
   end

   assign grant_count = r_grant_count;
`else
   assign grant_count = '0;
`endif

endmodule

// File: tb/tb_spn_cu_arbiter.sv
// tb/tb_spn_cu_arbiter.sv - Self-checking bench for spn_cu_arbiter driving a behavioural SPN core.
`timescale 1ns/1ps
module tb_spn_cu_arbiter;

   localparam int NUM_REQ = 4;
   localparam int KEY_W   = 32;

   logic                          clk = 1'b0;
   logic                          rst;
   logic [NUM_REQ-1:0]            req_valid, req_ready, resp_valid, resp_ready;
   logic [NUM_REQ-1:0][1:0]       req_opcode;
   logic [NUM_REQ-1:0][15:0]      req_data;
   logic [NUM_REQ-1:0][KEY_W-1:0] req_key;
   logic [15:0]                   resp_data;
   logic [1:0]                    resp_status;
   logic [1:0]                    core_opcode;
   logic [15:0]                   core_data_in;
   logic [KEY_W-1:0]              core_key;
   logic [15:0]                   core_data_out;
   logic [1:0]                    core_valid;
   logic                          busy, err_sticky;
   logic [NUM_REQ-1:0][15:0]      grant_count;
   logic                          inject;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      int          src;
      logic [1:0]  op;
      logic [15:0] data;
      logic [31:0] key;
      logic        inject;
      logic [15:0] exp_data;
      logic [1:0]  exp_status;
      logic        exp_err;
   } vec_t;

   typedef struct {
      int          src;
      logic [15:0] data;
      logic [1:0]  status;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   tally[NUM_REQ];
   vec_t vecs[6];

   always #5 clk = ~clk;

   spn_cu_arbiter #(.NUM_REQ(NUM_REQ), .KEY_W(KEY_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_opcode    (req_opcode),
      .req_data      (req_data),
      .req_key       (req_key),
      .resp_valid    (resp_valid),
      .resp_ready    (resp_ready),
      .resp_data     (resp_data),
      .resp_status   (resp_status),
      .core_opcode   (core_opcode),
      .core_data_in  (core_data_in),
      .core_key      (core_key),
      .core_data_out (core_data_out),
      .core_valid    (core_valid),
      .busy          (busy),
      .err_sticky    (err_sticky),
      .grant_count   (grant_count)
   );

   function automatic logic [3:0] sbox4(input logic [3:0] x);
      logic [3:0] y;
      case (x)
         4'h0: y = 4'hE; 4'h1: y = 4'h4; 4'h2: y = 4'hD; 4'h3: y = 4'h1;
         4'h4: y = 4'h2; 4'h5: y = 4'hF; 4'h6: y = 4'hB; 4'h7: y = 4'h8;
         4'h8: y = 4'h3; 4'h9: y = 4'hA; 4'hA: y = 4'h6; 4'hB: y = 4'hC;
         4'hC: y = 4'h5; 4'hD: y = 4'h9; 4'hE: y = 4'h0; default: y = 4'h7;
      endcase
      return y;
   endfunction

   function automatic logic [15:0] spn_ref(input logic [1:0] op, input logic [15:0] d,
                                           input logic [31:0] k);
      logic [15:0] x;
      x = d ^ k[15:0];
      x = {sbox4(x[15:12]), sbox4(x[11:8]), sbox4(x[7:4]), sbox4(x[3:0])};
      case (op)
         2'b01:   x = {x[11:0], x[15:12]} ^ k[31:16];
         2'b10:   x = {x[3:0], x[15:4]} ^ ~k[31:16];
         default: x = x ^ 16'hFFFF;
      endcase
      return x;
   endfunction

   function automatic logic [1:0] core_status(input logic [1:0] op);
      case (op)
         2'b01:   return 2'b01;
         2'b10:   return 2'b10;
         2'b11:   return 2'b11;
         default: return 2'b00;
      endcase
   endfunction

   function automatic logic [NUM_REQ-1:0] onehot(input int i);
      return NUM_REQ'(1) << i;
   endfunction

   function automatic vec_t make_vec(input int src, input logic [1:0] op, input logic [15:0] d,
                                     input logic [31:0] k, input logic inj, input logic err);
      vec_t v;
      v.src = src; v.op = op; v.data = d; v.key = k; v.inject = inj; v.exp_err = err;
      if (op == 2'b00) begin
         v.exp_data = 16'h0000; v.exp_status = 2'b00;
      end else begin
         v.exp_data   = spn_ref(op, d, k);
         v.exp_status = inj ? 2'b11 : core_status(op);
      end
      return v;
   endfunction

   // Behavioural core: registers its result on the edge that ends the issue cycle.
   always @(posedge clk) begin
      if (rst) begin
         core_data_out <= '0;
         core_valid    <= 2'b00;
      end else begin
         core_valid <= 2'b00;
         if (core_opcode != 2'b00) begin
            core_data_out <= spn_ref(core_opcode, core_data_in, core_key);
            core_valid    <= inject ? 2'b00 : core_status(core_opcode);
         end
      end
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
         for (int i = 0; i < NUM_REQ; i++) tally[i] = 0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) tally[i]++;
         if ((resp_valid & resp_ready) != '0) begin
            if (sb.size() == 0) begin
               n_cmp++; n_fail++;
               $display("FAIL sb_empty: response %b with no expected entry", resp_valid);
            end else begin
               mon_e = sb.pop_front();
               check("resp_onehot", 64'(resp_valid), 64'(onehot(mon_e.src)));
               check("resp_data", 64'(resp_data), 64'(mon_e.data));
               check("resp_status", 64'(resp_status), 64'(mon_e.status));
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; req_valid = '0; resp_ready = '0; inject = 1'b0;
      cyc(); cyc();
      rst = 1'b0;
   endtask

   task automatic check_counts();
      for (int i = 0; i < NUM_REQ; i++) begin
`ifdef SPN_ARB_STATS_EN
         check("grant_count", 64'(grant_count[i]), 64'(tally[i]));
`else
         check("grant_count", 64'(grant_count[i]), 64'd0);
`endif
      end
   endtask

   task automatic do_txn(input vec_t v);
      int lat, n_iss, exp_lat;
      logic [1:0] last_op;
      exp_t e;
      inject = v.inject;
      req_opcode[v.src] = v.op; req_data[v.src] = v.data; req_key[v.src] = v.key;
      req_valid  = onehot(v.src);
      resp_ready = onehot(v.src);
      @(negedge clk);
      check("grant", 64'(req_ready), 64'(onehot(v.src)));
      e.src = v.src; e.data = v.exp_data; e.status = v.exp_status;
      sb.push_back(e);
      lat = 0; n_iss = 0; last_op = 2'b00;
      exp_lat = (v.op == 2'b00) ? 1 : 3;
      do begin
         cyc();
         req_valid = '0;
         lat++;
         @(negedge clk);
         if (core_opcode != 2'b00) begin n_iss++; last_op = core_opcode; end
      end while (!resp_valid[v.src] && lat < 20);
      check("latency", 64'(lat), 64'(exp_lat));
      check("issue_cycles", 64'(n_iss), (v.op == 2'b00) ? 64'd0 : 64'd1);
      if (v.op != 2'b00) check("issue_opcode", 64'(last_op), 64'(v.op));
      cyc();
      resp_ready = '0; inject = 1'b0;
      @(negedge clk);
      check("resp_valid_drop", 64'(resp_valid), 64'd0);
      check("busy_idle", 64'(busy), 64'd0);
      check("err_sticky", 64'(err_sticky), 64'(v.exp_err));
      cyc();
   endtask

   task automatic run_stream(input logic [NUM_REQ-1:0] mask, input logic [1:0] op, input int n,
                             input int order[8], input logic drop, input string tag);
      int t, prev, g;
      exp_t e;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_opcode[i] = op;
         req_data[i]   = 16'h3C00 + 16'(i * 16'h0111);
         req_key[i]    = 32'h0F1E_2D3C ^ (32'(i) << 8);
      end
      req_valid = mask; resp_ready = '1;
      t = 0; prev = 0; g = 0;
      while (g < n && t < 60) begin
         @(negedge clk);
         if (req_ready != '0) begin
            check({tag, "_order"}, 64'(req_ready), 64'(onehot(order[g])));
            if (g > 0) check({tag, "_spacing"}, 64'(t - prev), 64'd4);
            prev = t;
            e.src = order[g];
            e.data = spn_ref(op, req_data[order[g]], req_key[order[g]]);
            e.status = core_status(op);
            sb.push_back(e);
            g++;
            cyc(); t++;
            if (drop || g == n) req_valid[order[g-1]] = 1'b0;
         end else begin
            cyc(); t++;
         end
      end
      check({tag, "_grants"}, 64'(g), 64'(n));
      req_valid = '0;
      for (int i = 0; i < 6; i++) cyc();
      resp_ready = '0;
      @(negedge clk);
      check({tag, "_drained"}, 64'(sb.size()), 64'd0);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      cyc();
   endtask

   initial begin
      int ord[8];
      logic stable;
      exp_t e;
      rst = 1'b1; req_valid = '0; resp_ready = '0; inject = 1'b0;
      req_opcode = '0; req_data = '0; req_key = '0;

      vecs[0] = make_vec(0, 2'b01, 16'h1234, 32'hA5A5_5A5A, 1'b0, 1'b0);
      vecs[1] = make_vec(1, 2'b10, 16'hBEEF, 32'h1234_5678, 1'b0, 1'b0);
      vecs[2] = make_vec(3, 2'b11, 16'h0F0F, 32'hCAFE_F00D, 1'b0, 1'b0);
      vecs[3] = make_vec(2, 2'b00, 16'h7777, 32'h0000_FFFF, 1'b0, 1'b0);
      vecs[4] = make_vec(0, 2'b01, 16'h4321, 32'h0BAD_C0DE, 1'b1, 1'b1);
      vecs[5] = make_vec(1, 2'b01, 16'hFFFF, 32'hFFFF_0000, 1'b0, 1'b1);

      cyc(); cyc();
      @(negedge clk);
      check("rst_req_ready", 64'(req_ready), 64'd0);
      check("rst_resp_valid", 64'(resp_valid), 64'd0);
      check("rst_resp_data", 64'(resp_data), 64'd0);
      check("rst_resp_status", 64'(resp_status), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_err", 64'(err_sticky), 64'd0);
      check("rst_core_opcode", 64'(core_opcode), 64'd0);
      check("rst_core_data", 64'(core_data_in), 64'd0);
      check("rst_core_key", 64'(core_key), 64'd0);
      check_counts();
      cyc();
      rst = 1'b0;

      for (int i = 0; i < 6; i++) do_txn(vecs[i]);

      do_reset();
      ord = '{0, 1, 2, 3, 0, 0, 0, 0};
      run_stream(4'b1111, 2'b10, 4, ord, 1'b1, "rotate");
      check_counts();

      ord = '{0, 0, 0, 0, 0, 0, 0, 0};
      run_stream(4'b0001, 2'b01, 3, ord, 1'b0, "b2b");

      req_opcode[1] = 2'b01; req_data[1] = 16'h55AA; req_key[1] = 32'hDEAD_BEEF;
      req_valid = 4'b0010; resp_ready = '0;
      @(negedge clk);
      check("bp_grant", 64'(req_ready), 64'(onehot(1)));
      e.src = 1; e.data = spn_ref(2'b01, 16'h55AA, 32'hDEAD_BEEF); e.status = 2'b01;
      cyc(); req_valid = '0;
      cyc(); cyc();
      @(negedge clk);
      check("bp_resp_valid", 64'(resp_valid), 64'(onehot(1)));
      cyc();
      req_opcode[2] = 2'b01; req_valid = 4'b0100; resp_ready = 4'b1000;
      stable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (resp_valid !== onehot(1) || resp_data !== e.data || resp_status !== e.status ||
             req_ready !== '0 || busy !== 1'b1) stable = 1'b0;
         cyc();
      end
      check("bp_stable", 64'(stable), 64'd1);

      rst = 1'b1;
      cyc();
      @(negedge clk);
      check("mid_rst_resp_valid", 64'(resp_valid), 64'd0);
      check("mid_rst_req_ready", 64'(req_ready), 64'd0);
      check("mid_rst_resp_data", 64'(resp_data), 64'd0);
      check("mid_rst_resp_status", 64'(resp_status), 64'd0);
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_core_opcode", 64'(core_opcode), 64'd0);
      cyc();
      rst = 1'b0; resp_ready = '0;
      req_opcode[0] = 2'b01; req_valid = 4'b0101;
      @(negedge clk);
      check("ptr_restart", 64'(req_ready), 64'(onehot(0)));
      cyc();
      do_reset();
      @(negedge clk);
      check("final_sb_empty", 64'(sb.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/spn_cu_arbiter.md
Name: spn_cu_arbiter

Overview:
Round-robin scheduler that shares one SPN cryptographic unit (spn_cu_top datapath) between NUM_REQ requesters. It accepts one request at a time (opcode, 16-bit block, secret key) and drives the core's opcode, data and key inputs for one cycle. It then captures the core's registered result and status code and returns them to the granted requester with a valid/ready response handshake. It sits between the requester fabric and the spn_if core interface, and the core shares its clock and reset.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
KEY_W, 32, width of symmetric secret key
ID_W, $clog2(NUM_REQ), requester index width (derived, not overridden)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  [NUM_REQ]  request present, held until accepted
req_ready  out  [NUM_REQ]  one-hot acceptance pulse
req_opcode  in  [NUM_REQ][2]  opcode per requester
req_data  in  [NUM_REQ][16]  plaintext/ciphertext per requester
req_key  in  [NUM_REQ][KEY_W]  secret key per requester
resp_valid  out  [NUM_REQ]  one-hot response valid
resp_ready  in  [NUM_REQ]  response accept
resp_data  out  16  result block (shared)
resp_status  out  2  status code from spn_cu_pkg (shared)
core_opcode  out  2  to core opcode
core_data_in  out  16  to core data_in
core_key  out  KEY_W  to core symmetric_secret_key
core_data_out  in  16  from core data_out
core_valid  in  2  from core valid
busy  out  1  high whenever state is not IDLE
err_sticky  out  1  set when a core status mismatches its expected value; cleared only by rst
grant_count  out  [NUM_REQ][16]  per-requester grant counters (see Optional Feature)

Behaviour:
- Reset (synchronous, rst high at posedge):
  - state=IDLE, rr pointer=NUM_REQ-1 (requester 0 has first priority).
  - core_opcode=no_op; core_data_in and core_key=0.
  - req_ready, resp_valid, resp_data, resp_status, err_sticky, busy and grant_count all 0.
  - Reset mid-operation abandons the transaction silently; no response is issued.
- FSM states:
  - IDLE: combinational round-robin pick over req_valid, starting from pointer+1 and wrapping modulo NUM_REQ.
    - If any request is valid: req_ready[g]=1 for that cycle only. Latch opcode/data/key and g; pointer<=g.
    - If the opcode is no_op: go to RESP with resp_status=not_valid and resp_data=0. The core is not used.
    - Otherwise: go to ISSUE.
    - If no request is valid: stay in IDLE.
  - ISSUE (1 cycle): core_opcode, core_data_in and core_key are driven from the latches; the core registers its result on this edge. Go to CAPTURE.
  - CAPTURE (1 cycle): core_opcode=no_op. Sample core_data_out into resp_data and core_valid into resp_status.
    - Expected status: encrypt→successful_encryption, decrypt→successful_decryption, undefined→internal_error_or_undefined.
    - On mismatch: force resp_status=internal_error_or_undefined and set err_sticky. Go to RESP.
  - RESP: resp_valid[g]=1; resp_data and resp_status are held stable.
    - When resp_ready[g]: go to IDLE, and resp_valid drops the next cycle.
    - resp_ready on any other index is ignored.
- Latency and throughput:
  - Acceptance to resp_valid is 3 cycles for core ops and 1 cycle for no_op.
  - Maximum throughput is one core op per 4 cycles.
- Boundary conditions:
  - No new grant is made while the FSM is outside IDLE; req_ready stays 0.
  - Simultaneous requests from all requesters are served in strict rotation.
  - A single continuously requesting source is re-granted back-to-back.
  - core_opcode is no_op in every state except ISSUE.

Optional Feature:
SPN_ARB_STATS_EN
- Defined: grant_count[i] increments on each grant to requester i and saturates at 16'hFFFF. It resets to 0.
- Undefined: no counter logic is built and grant_count is tied to 0.

Decomposition:
- spn_cu_pkg gains spn_arb_state_t (IDLE, ISSUE, CAPTURE, RESP).
- The arbiter reuses the existing opcode and valid-code constants:
  - Opcodes: no_op=00, encrypt=01, decrypt=10, undefined=11.
  - Status codes: not_valid=00, successful_encryption=01, successful_decryption=10, internal_error_or_undefined=11.
- Sub-module spn_rr_arbiter: combinational. Inputs are request vector and pointer; outputs are a one-hot grant and a grant index.

Test Plan:
- Single request: req0 encrypt, data=16'h1234, key=32'hA5A5_5A5A → req_ready[0] pulses in cycle 0. resp_valid[0] rises in cycle 3 with resp_data equal to the reference-model ciphertext and resp_status=01.
- All four requesters valid with decrypt from reset → grants in order 0,1,2,3 at 4-cycle spacing with zero-stall resp_ready. Each resp_status=10.
- Opcode undefined → resp_status=11 and err_sticky stays 0. Injecting core_valid=00 during CAPTURE of an encrypt → resp_status=11 and err_sticky=1.
- No-op request on req2 → resp_valid[2] one cycle after acceptance, resp_status=00, core_opcode never leaves 00.
- Backpressure: hold resp_ready=0 for 10 cycles → resp_valid/resp_data/resp_status stable, no new req_ready. Asserting rst during RESP → all outputs 0 next cycle and pointer restarts at requester 0.
